// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if
// Handshake and data bundle between a producer of binary values and the
// sequential binary-to-BCD converter.
//   start   : request a conversion of bin_in (producer -> converter)
//   bin_in  : W-bit unsigned value to convert (producer -> converter)
//   busy    : conversion in progress (converter -> producer)
//   done    : one-cycle pulse, bcd_out carries the new result (converter -> producer)
//   bcd_out : 8 packed BCD digits, digit 0 in [3:0] (converter -> producer)
interface bin_to_bcd_seq_if #(
  parameter int W = 16
);

  logic          start;
  logic [W-1:0]  bin_in;
  logic          busy;
  logic          done;
  logic [31:0]   bcd_out;

  // The producer drives the request side and observes the result side
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  // The converter takes the request side and drives the result side
  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential shift-and-add-3 (double dabble) converter that turns a W-bit
// unsigned value into 8 packed BCD digits for the seven-segment driver.
// One input bit is consumed per clock; the last result is held on bcd_out
// until the next conversion finishes, so the display never sees partial values.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous, active-high; clears all state immediately
//   bus   : bin_to_bcd_seq_if slave modport (start, bin_in, busy, done, bcd_out)
module bin_to_bcd_seq #(
  parameter int W = 16
) (
  input  logic              clock,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   bus
);

  // 2^26-1 is the largest value that still fits in eight decimal digits
  if (W < 1 || W > 26) begin : g_bad_width
    $error("bin_to_bcd_seq: W must be in 1..26");
  end

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bin_sr_q, bin_sr_d;
  logic [31:0]    scratch_q, scratch_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    bcd_q, bcd_d;
  logic           done_q, done_d;

  logic [31:0]    adjusted;
  logic [31:0]    shifted;

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit; digits never exceed 12
  // here, so the add stays inside its own nibble.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[30:0], bin_sr_q[W-1]};
  end

  // Next-state logic: accept a request in IDLE, otherwise run one
  // adjust+shift iteration per clock and publish the result on the last one.
  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_sr_d  = bus.bin_in;
          scratch_d = 32'h0;
          cnt_d     = CW'(W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        bin_sr_d  = bin_sr_q << 1;
        cnt_d     = cnt_q - 1'b1;
        // The final shifted value goes straight to the output register so
        // the result and the done pulse appear in the same cycle.
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any conversion and clears the display value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      scratch_q <= 32'h0;
      cnt_q     <= '0;
      bcd_q     <= 32'h0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
// Directed and random checks of bin_to_bcd_seq at W=16 and W=26 sharing one
// clock and reset.
module tb_bin_to_bcd_seq;

  logic clock;
  logic reset;

  bin_to_bcd_seq_if #(.W(16)) bus16 ();
  bin_to_bcd_seq_if #(.W(26)) bus26 ();

  bin_to_bcd_seq #(.W(16)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16.slave)
  );

  bin_to_bcd_seq #(.W(26)) dut26 (
    .clock (clock),
    .reset (reset),
    .bus   (bus26.slave)
  );

  int vectors;
  int miscompares;

  // 100 MHz-style free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its expected value and log a miss
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference conversion: integer to packed decimal digits
  function automatic logic [31:0] toBcd(input int unsigned value);
    logic [31:0] r;
    int unsigned v;
    r = 32'h0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic doneOf(input int sel);
    return (sel == 16) ? bus16.done : bus26.done;
  endfunction

  // Start one conversion on the chosen instance and wait (bounded) for done;
  // lat is the number of edges from the accepting edge to the done edge.
  task automatic applyStimulus(input int sel, input logic [25:0] value,
                               output int lat);
    if (sel == 16) begin
      bus16.start  = 1'b1;
      bus16.bin_in = value[15:0];
    end else begin
      bus26.start  = 1'b1;
      bus26.bin_in = value;
    end
    tick();
    bus16.start = 1'b0;
    bus26.start = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!doneOf(sel) && lat < 40);
  endtask

  int lat;
  int done_count;
  int pulse_at [3];
  logic [31:0] exp_seq [3];
  logic [25:0] rnd;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus16.start  = 1'b0;
    bus16.bin_in = '0;
    bus26.start  = 1'b0;
    bus26.bin_in = '0;
    tick();
    tick();
    checkOutput("rst_bcd16", bus16.bcd_out, 32'h0);
    checkOutput("rst_busy16", 32'(bus16.busy), 32'h0);
    checkOutput("rst_done16", 32'(bus16.done), 32'h0);
    checkOutput("rst_bcd26", bus26.bcd_out, 32'h0);
    reset = 1'b0;
    tick();

    // Zero input: busy for 16 cycles, then a single done with 0
    bus16.start  = 1'b1;
    bus16.bin_in = 16'd0;
    tick();
    bus16.start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("zero_busy_c%0d", i), 32'(bus16.busy), 32'h1);
      checkOutput($sformatf("zero_nodone_c%0d", i), 32'(bus16.done), 32'h0);
      tick();
    end
    checkOutput("zero_done", 32'(bus16.done), 32'h1);
    checkOutput("zero_busy_end", 32'(bus16.busy), 32'h0);
    checkOutput("zero_bcd", bus16.bcd_out, 32'h0);

    // Largest 16-bit value, latency and one-cycle done width
    tick();
    applyStimulus(16, 26'd65535, lat);
    checkOutput("max16_lat", 32'(lat), 32'd16);
    checkOutput("max16_bcd", bus16.bcd_out, 32'h00065535);
    tick();
    checkOutput("max16_done_width", 32'(bus16.done), 32'h0);
    checkOutput("max16_hold", bus16.bcd_out, 32'h00065535);

    // Start while busy is ignored
    bus16.start  = 1'b1;
    bus16.bin_in = 16'd1234;
    tick();
    bus16.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus16.start  = 1'b1;
    bus16.bin_in = 16'd9999;
    tick();
    bus16.start = 1'b0;
    lat = 0;
    while (!bus16.done && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("ignore_bcd", bus16.bcd_out, 32'h00001234);
    tick();
    checkOutput("ignore_no_requeue", 32'(bus16.busy), 32'h0);
    applyStimulus(16, 26'd9999, lat);
    checkOutput("later_9999", bus16.bcd_out, 32'h00009999);

    // Asynchronous reset in the middle of a conversion
    tick();
    bus16.start  = 1'b1;
    bus16.bin_in = 16'd4321;
    tick();
    bus16.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_bcd", bus16.bcd_out, 32'h0);
    checkOutput("abort_busy", 32'(bus16.busy), 32'h0);
    checkOutput("abort_done", 32'(bus16.done), 32'h0);
    tick();
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus16.done) done_count++;
    end
    checkOutput("abort_no_done", 32'(done_count), 32'h0);
    applyStimulus(16, 26'd4321, lat);
    checkOutput("after_abort_bcd", bus16.bcd_out, 32'h00004321);

    // Back-to-back conversions with start held high
    tick();
    exp_seq[0]   = 32'h00000010;
    exp_seq[1]   = 32'h00000099;
    exp_seq[2]   = 32'h00000100;
    done_count   = 0;
    bus16.start  = 1'b1;
    bus16.bin_in = 16'd10;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus16.done && done_count < 3) begin
        checkOutput($sformatf("b2b_bcd%0d", done_count), bus16.bcd_out,
                    exp_seq[done_count]);
        pulse_at[done_count] = i;
        done_count++;
        if (done_count == 1) bus16.bin_in = 16'd99;
        if (done_count == 2) bus16.bin_in = 16'd100;
        if (done_count == 3) bus16.start = 1'b0;
      end
    end
    bus16.start = 1'b0;
    checkOutput("b2b_count", 32'(done_count), 32'd3);
    if (done_count == 3) begin
      checkOutput("b2b_first", 32'(pulse_at[0]), 32'd17);
      checkOutput("b2b_space1", 32'(pulse_at[1] - pulse_at[0]), 32'd17);
      checkOutput("b2b_space2", 32'(pulse_at[2] - pulse_at[1]), 32'd17);
    end

    // Full-scale 26-bit conversion
    applyStimulus(26, 26'd67108863, lat);
    checkOutput("max26_lat", 32'(lat), 32'd26);
    checkOutput("max26_bcd", bus26.bcd_out, 32'h67108863);
    tick();
    checkOutput("max26_done_width", 32'(bus26.done), 32'h0);

    // Random sweep against the integer reference
    for (int n = 0; n < 1000; n++) begin
      rnd = 26'($urandom_range(0, 67108863));
      applyStimulus(26, rnd, lat);
      checkOutput($sformatf("rnd26_%0d", rnd), bus26.bcd_out, toBcd(32'(rnd)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
